// File: rtl/syn_current_accum.sv
// Synaptic current accumulator: walks a latched spike vector and sums sign-magnitude weights.
// Optional SYN_BIAS_EN: seed the accumulator with the bias port instead of zero.
module syn_current_accum #(
    parameter int N      = 35,
    parameter int Q      = 32,
    parameter int NUM_IN = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_IN-1:0] spikes,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [N-1:0]      wr_data,
    input  logic [N-1:0]      bias,
    output logic [N-1:0]      current,
    output logic              flag_out,
    output logic              busy
);

    localparam int M = N - 1;
    localparam int unused_q = Q;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [N-1:0]      acc;
    logic [NUM_IN-1:0] spk;
    logic [N-1:0]      weights [NUM_IN];
    logic [N-1:0]      seed;

    function automatic logic [N-1:0] sm_norm(input logic [N-1:0] a);
        logic [N-1:0] r;
        r = a;
        if (a[M-1:0] == '0) r = '0;
        return r;
    endfunction

    // Saturating sign-magnitude add; negative zero never escapes.
    function automatic logic [N-1:0] sm_add(input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [M-1:0] ma, mb;
        logic         sa, sb;
        logic [M:0]   sum;
        logic [N-1:0] r;
        ma  = a[M-1:0];
        mb  = b[M-1:0];
        sa  = a[N-1] & (ma != '0);
        sb  = b[N-1] & (mb != '0);
        sum = '0;
        if (sa == sb) begin
            sum = {1'b0, ma} + {1'b0, mb};
            if (sum[M]) r = {sa, {M{1'b1}}};
            else        r = {sa, sum[M-1:0]};
        end else if (ma >= mb) begin
            r = {sa, ma - mb};
        end else begin
            r = {sb, mb - ma};
        end
        return sm_norm(r);
    endfunction

`ifdef SYN_BIAS_EN
    assign seed = sm_norm(bias);
`else
    logic unused_bias;
    assign unused_bias = ^bias;
    assign seed = '0;
`endif

    assign busy = (state != IDLE);

    // Weight file has no reset so writes land even on a reset edge.
    always_ff @(posedge clock) begin
        if (wr_en) weights[wr_addr] <= wr_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            spk      <= '0;
            current  <= '0;
            flag_out <= 1'b0;
        end else begin
            flag_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        spk   <= spikes;
                        acc   <= seed;
                        idx   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (spk[idx]) acc <= sm_add(acc, weights[idx]);
                    if (idx == IDX_W'(NUM_IN - 1)) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    current  <= acc;
                    flag_out <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syn_current_accum.sv
// Directed self-checking bench for syn_current_accum.
module tb_syn_current_accum;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] spikes;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [34:0] wr_data;
    logic [34:0] bias;
    logic [34:0] current;
    logic        flag_out;
    logic        busy;

    int vectors;
    int miscompares;

    syn_current_accum dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .spikes   (spikes),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .bias     (bias),
        .current  (current),
        .flag_out (flag_out),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [34:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick;
        wr_en   = 1'b0;
    endtask

    task automatic wr_all(input logic [34:0] d);
        for (int i = 0; i < 16; i++) wr(4'(i), d);
    endtask

    task automatic no_flag(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            tick;
            if (flag_out) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    task automatic run(input string tag, input logic [15:0] spk,
                       input logic [34:0] exp, input bit mid_start,
                       input bit mid_wr, input logic [3:0] wa,
                       input logic [34:0] wd);
        int lat;
        lat    = 0;
        spikes = spk;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        spikes = ~spk;
        chk({tag, ".busy_hi"}, 64'(busy), 64'd1);
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            wr_en = 1'b0;
            start = (mid_start && c == 3);
            if (mid_wr && c == 5) begin
                wr_en   = 1'b1;
                wr_addr = wa;
                wr_data = wd;
            end
            tick;
            if (flag_out) lat = c;
        end
        wr_en = 1'b0;
        start = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'd17);
        chk({tag, ".current"}, 64'(current), 64'(exp));
        tick;
        chk({tag, ".flag_drop"}, 64'(flag_out), 64'd0);
        chk({tag, ".busy_lo"}, 64'(busy), 64'd0);
        chk({tag, ".hold"}, 64'(current), 64'(exp));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        start   = 1'b0;
        spikes  = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        bias    = '0;
        tick;
        tick;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.flag", 64'(flag_out), 64'd0);
        chk("rst.current", 64'(current), 64'd0);
        reset = 1'b0;
        tick;
        chk("idle.busy", 64'(busy), 64'd0);

        wr_all(35'h0_8000_0000);
        run("t1", 16'h000F, 35'h2_0000_0000, 1'b0, 1'b0, 4'd0, 35'h0);

        wr(4'd0, 35'h1_0000_0000);
        wr(4'd1, 35'h5_8000_0000);
        run("t2", 16'h0003, 35'h4_8000_0000, 1'b0, 1'b0, 4'd0, 35'h0);

        wr(4'd1, 35'h5_0000_0000);
        run("t3", 16'h0003, 35'h0_0000_0000, 1'b0, 1'b0, 4'd0, 35'h0);

        wr_all(35'h3_0000_0000);
        run("t4", 16'hFFFF, 35'h3_FFFF_FFFF, 1'b0, 1'b0, 4'd0, 35'h0);

        spikes = 16'hFFFF;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        tick;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        tick;
        tick;
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 35'h1_0000_0000;
        tick;
        reset = 1'b0;
        wr_en = 1'b0;
        chk("t5.busy", 64'(busy), 64'd0);
        chk("t5.flag", 64'(flag_out), 64'd0);
        chk("t5.current", 64'(current), 64'd0);
        no_flag("t5.no_flag", 24);
        chk("t5.still_idle", 64'(busy), 64'd0);

        bias = 35'h4_8000_0000;
`ifdef SYN_BIAS_EN
        run("t6", 16'h0001, 35'h0_8000_0000, 1'b1, 1'b0, 4'd0, 35'h0);
`else
        run("t6", 16'h0001, 35'h1_0000_0000, 1'b1, 1'b0, 4'd0, 35'h0);
`endif
        no_flag("t6.no_queue", 20);
        bias = '0;

        wr(4'd2, 35'h0_8000_0000);
        run("t7a", 16'h0005, 35'h1_8000_0000, 1'b0, 1'b1, 4'd0,
            35'h3_0000_0000);
        run("t7b", 16'h0005, 35'h3_8000_0000, 1'b0, 1'b0, 4'd0, 35'h0);

        wr(4'd3, 35'h4_0000_0000);
        run("t8", 16'h0009, 35'h3_0000_0000, 1'b0, 1'b0, 4'd0, 35'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
